stopwatch_fnd_ctrl: RTL

- Display-side reader for the stopwatch/clock time datapath. Consumes the msec/sec/minute/hour counts and drives a 4-digit common-anode 7-segment (FND) module by time-multiplexed scanning.
- Per refresh frame: snapshots the time inputs, splits the selected fields into decimal digits, encodes them to segment fonts, and blinks the decimal point at 1 Hz.

---
 rtl/fnd_pkg.sv | 41 ++++
 rtl/fnd_seg_decoder.sv | 39 +++
 rtl/stopwatch_fnd_ctrl.sv | 129 ++++++++++++
 3 files changed

// File: rtl/fnd_pkg.sv
// Shared definitions for the stopwatch FND display path: segment fonts,
// display mode encoding, legal field limits and constant /10 helpers.
package fnd_pkg;

  // Active-low segment fonts, bit order {dp,g,f,e,d,c,b,a}
  localparam logic [7:0] FONT_0     = 8'hC0;
  localparam logic [7:0] FONT_1     = 8'hF9;
  localparam logic [7:0] FONT_2     = 8'hA4;
  localparam logic [7:0] FONT_3     = 8'hB0;
  localparam logic [7:0] FONT_4     = 8'h99;
  localparam logic [7:0] FONT_5     = 8'h92;
  localparam logic [7:0] FONT_6     = 8'h82;
  localparam logic [7:0] FONT_7     = 8'hF8;
  localparam logic [7:0] FONT_8     = 8'h80;
  localparam logic [7:0] FONT_9     = 8'h90;
  localparam logic [7:0] FONT_DASH  = 8'hBF;
  localparam logic [7:0] FONT_BLANK = 8'hFF;

  typedef enum logic {
    MODE_SEC_MSEC = 1'b0,
    MODE_HOUR_MIN = 1'b1
  } mode_e;

  // First illegal value of each time field
  localparam logic [6:0] LIM_MSEC = 7'd100;
  localparam logic [5:0] LIM_SEC  = 6'd60;
  localparam logic [5:0] LIM_MIN  = 6'd60;
  localparam logic [4:0] LIM_HOUR = 5'd24;

  // floor(v/10) as (v*205)>>11, exact for every 7-bit input
  function automatic logic [3:0] div10(input logic [6:0] v);
    logic [14:0] p;
    p = {8'b0, v} * 15'd205;
    return p[14:11];
  endfunction

  function automatic logic [3:0] mod10(input logic [6:0] v);
    return 4'(v - {3'b0, div10(v)} * 7'd10);
  endfunction

endpackage

// File: rtl/fnd_seg_decoder.sv
// Digit value to active-low 7-segment font. Blank wins over dash, dash
// wins over the numeral; dp is only applied to a numeral.
module fnd_seg_decoder
  import fnd_pkg::*;
(
  input  logic [3:0] val_i,
  input  logic       blank_i,
  input  logic       dash_i,
  input  logic       dp_i,
  output logic [7:0] font_o
);

  logic [7:0] num_font;

  // Numeral lookup, values above 9 fall back to blank
  always_comb begin
    case (val_i)
      4'd0:    num_font = FONT_0;
      4'd1:    num_font = FONT_1;
      4'd2:    num_font = FONT_2;
      4'd3:    num_font = FONT_3;
      4'd4:    num_font = FONT_4;
      4'd5:    num_font = FONT_5;
      4'd6:    num_font = FONT_6;
      4'd7:    num_font = FONT_7;
      4'd8:    num_font = FONT_8;
      4'd9:    num_font = FONT_9;
      default: num_font = FONT_BLANK;
    endcase
  end

  // Overrides and decimal point (active-low bit7)
  always_comb begin
    if (blank_i)     font_o = FONT_BLANK;
    else if (dash_i) font_o = FONT_DASH;
    else             font_o = num_font & {~dp_i, 7'h7F};
  end

endmodule

// File: rtl/stopwatch_fnd_ctrl.sv
// 4-digit multiplexed FND driver for the stopwatch time counts.
// A coherent snapshot of the time inputs is taken once per frame; each
// digit slot lasts SCAN_DIV clocks. Optional build macro:
//   FND_LEAD_ZERO_BLANK_EN - blank digit3 when it would show a leading 0.
module stopwatch_fnd_ctrl
  import fnd_pkg::*;
#(
  parameter int SCAN_DIV = 100_000
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [6:0] msec,
  input  logic [5:0] sec,
  input  logic [5:0] minute,
  input  logic [4:0] hour,
  input  logic       sel_mode,
  output logic [3:0] fnd_comm,
  output logic [7:0] fnd_font
);

  localparam int            CW       = $clog2(SCAN_DIV);
  localparam logic [CW-1:0] CNT_LAST = CW'(SCAN_DIV - 1);

  logic [CW-1:0] scan_cnt_q, scan_cnt_d;
  logic [1:0]    digit_idx_q, digit_idx_d;
  logic          slot_end, frame_end;

  logic [6:0] msec_s_q;
  logic [5:0] sec_s_q, minute_s_q;
  logic [4:0] hour_s_q;
  mode_e      mode_s_q;

  logic [6:0] low_fld, high_fld;
  logic       oor;
  logic [3:0] dig_val;
  logic       dig_dp, dig_blank;
  logic [7:0] font_d;

  // Slot counter and digit index advance
  always_comb begin
    slot_end    = (scan_cnt_q == CNT_LAST);
    frame_end   = slot_end && (digit_idx_q == 2'd3);
    scan_cnt_d  = slot_end ? '0 : scan_cnt_q + 1'b1;
    digit_idx_d = slot_end ? digit_idx_q + 2'd1 : digit_idx_q;
  end

  // Scan state registers
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      scan_cnt_q  <= '0;
      digit_idx_q <= 2'd0;
    end else begin
      scan_cnt_q  <= scan_cnt_d;
      digit_idx_q <= digit_idx_d;
    end
  end

  // Frame snapshot, captured as digit_idx wraps 3->0
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      msec_s_q   <= '0;
      sec_s_q    <= '0;
      minute_s_q <= '0;
      hour_s_q   <= '0;
      mode_s_q   <= MODE_SEC_MSEC;
    end else if (frame_end) begin
      msec_s_q   <= msec;
      sec_s_q    <= sec;
      minute_s_q <= minute;
      hour_s_q   <= hour;
      mode_s_q   <= mode_e'(sel_mode);
    end
  end

  // Field select and range check on the selected pair
  always_comb begin
    if (mode_s_q == MODE_HOUR_MIN) begin
      low_fld  = {1'b0, minute_s_q};
      high_fld = {2'b0, hour_s_q};
      oor      = (minute_s_q >= LIM_MIN) || (hour_s_q >= LIM_HOUR);
    end else begin
      low_fld  = msec_s_q;
      high_fld = {1'b0, sec_s_q};
      oor      = (msec_s_q >= LIM_MSEC) || (sec_s_q >= LIM_SEC);
    end
  end

  // Current digit value, dp and leading-zero blank
  always_comb begin
    dig_dp    = 1'b0;
    dig_blank = 1'b0;
    case (digit_idx_q)
      2'd0:    dig_val = mod10(low_fld);
      2'd1:    dig_val = div10(low_fld);
      2'd2: begin
        dig_val = mod10(high_fld);
        dig_dp  = (msec_s_q < 7'd50);
      end
      default: begin
        dig_val = div10(high_fld);
`ifdef FND_LEAD_ZERO_BLANK_EN
        dig_blank = (dig_val == 4'd0) && !oor;
`else
        dig_blank = 1'b0;
`endif
      end
    endcase
  end

  fnd_seg_decoder u_dec (
    .val_i   (dig_val),
    .blank_i (dig_blank),
    .dash_i  (oor),
    .dp_i    (dig_dp),
    .font_o  (font_d)
  );

  // Registered outputs, one clk behind digit_idx
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      fnd_comm <= 4'b1111;
      fnd_font <= FONT_BLANK;
    end else begin
      fnd_comm <= ~(4'b0001 << digit_idx_q);
      fnd_font <= font_d;
    end
  end

endmodule
